// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD req/ack operand protocol (requester and responder).
package gcd_pkg;

    // Requester protocol states; 3-bit encoding shared with the responder's state enum.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_REQ = 3'd1,
        A_REL = 3'd2,
        B_REQ = 3'd3,
        B_REL = 3'd4,
        RESP  = 3'd5
    } req_state_t;

endpackage

// File: rtl/gcd_sat_counter.sv
// Saturating up-counter used to measure protocol latency.
module gcd_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear wins over increment, and the count sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q = cnt_r;

endmodule

// File: rtl/gcd_requester.sv
// Initiator side of the 4-phase req/ack GCD operand protocol: takes an operand
// pair on a valid/ready command port, presents a then b to the responder and
// returns the result with its latency on a valid/ready response port.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int W     = 128,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    output logic             req,
    input  logic             ack,
    output logic [W-1:0]     loadVal,
    input  logic [W-1:0]     result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_gcd,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             busy
);

    req_state_t       state_r,      state_nxt_s;
    logic             req_r,        req_nxt_s;
    logic [W-1:0]     load_val_r,   load_val_nxt_s;
    logic [W-1:0]     b_r,          b_nxt_s;
    logic [W-1:0]     rsp_gcd_r,    rsp_gcd_nxt_s;
    logic [CNT_W-1:0] rsp_cycles_r, rsp_cycles_nxt_s;

    logic             cnt_clear_s;
    logic             cnt_inc_s;
    logic [CNT_W-1:0] cnt_q_s;
    logic [CNT_W-1:0] cnt_plus1_s;

    gcd_sat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear_s),
        .inc   (cnt_inc_s),
        .q     (cnt_q_s)
    );

    // Latency counts every edge while the responder handshake is in flight.
    always_comb begin
        cnt_inc_s = (state_r == A_REQ) || (state_r == A_REL) || (state_r == B_REQ);
    end

    // Captured latency includes the capture edge itself, saturating at all-ones.
    always_comb begin
        if (cnt_q_s == {CNT_W{1'b1}}) begin
            cnt_plus1_s = cnt_q_s;
        end else begin
            cnt_plus1_s = cnt_q_s + CNT_W'(1);
        end
    end

    // Next-state and next-output decode for the protocol FSM.
    always_comb begin
        state_nxt_s      = state_r;
        req_nxt_s        = req_r;
        load_val_nxt_s   = load_val_r;
        b_nxt_s          = b_r;
        rsp_gcd_nxt_s    = rsp_gcd_r;
        rsp_cycles_nxt_s = rsp_cycles_r;
        cnt_clear_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    // A zero operand would never let the responder finish, so answer locally.
                    if ((cmd_a == {W{1'b0}}) || (cmd_b == {W{1'b0}})) begin
                        rsp_gcd_nxt_s    = cmd_a | cmd_b;
                        rsp_cycles_nxt_s = {CNT_W{1'b0}};
                        state_nxt_s      = RESP;
                    end else begin
                        b_nxt_s        = cmd_b;
                        req_nxt_s      = 1'b1;
                        load_val_nxt_s = cmd_a;
                        cnt_clear_s    = 1'b1;
                        state_nxt_s    = A_REQ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            A_REQ: begin
                if (ack) begin
                    req_nxt_s   = 1'b0;
                    state_nxt_s = A_REL;
                end else begin
                    state_nxt_s = A_REQ;
                end
            end
            A_REL: begin
                // Never raise req again until the responder has dropped ack.
                if (!ack) begin
                    req_nxt_s      = 1'b1;
                    load_val_nxt_s = b_r;
                    state_nxt_s    = B_REQ;
                end else begin
                    state_nxt_s = A_REL;
                end
            end
            B_REQ: begin
                if (ack) begin
                    rsp_gcd_nxt_s    = result;
                    rsp_cycles_nxt_s = cnt_plus1_s;
                    req_nxt_s        = 1'b0;
                    state_nxt_s      = B_REL;
                end else begin
                    state_nxt_s = B_REQ;
                end
            end
            B_REL: begin
                if (!ack) begin
                    load_val_nxt_s = {W{1'b0}};
                    state_nxt_s    = RESP;
                end else begin
                    state_nxt_s = B_REL;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                req_nxt_s      = 1'b0;
                load_val_nxt_s = {W{1'b0}};
            end
        endcase
    end

    // State and registered protocol/response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            load_val_r   <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            rsp_gcd_r    <= {W{1'b0}};
            rsp_cycles_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            req_r        <= req_nxt_s;
            load_val_r   <= load_val_nxt_s;
            b_r          <= b_nxt_s;
            rsp_gcd_r    <= rsp_gcd_nxt_s;
            rsp_cycles_r <= rsp_cycles_nxt_s;
        end
    end

    assign req        = req_r;
    assign loadVal    = load_val_r;
    assign rsp_gcd    = rsp_gcd_r;
    assign rsp_cycles = rsp_cycles_r;
    assign cmd_ready  = (state_r == IDLE);
    assign rsp_valid  = (state_r == RESP);
    assign busy       = (state_r != IDLE);

endmodule
